// File: rtl/regfile_writeback_queue_if.sv
// Producer / register-file bundle for the writeback queue.
// The fwd1/fwd2 forwarding outputs exist only when WBQ_BYPASS_EN is defined.
interface regfile_writeback_queue_if #(
    parameter int DEPTH = 4
);
    logic                     wb_valid;
    logic                     wb_ready;
    logic [4:0]               wb_sel;
    logic [31:0]              wb_dat;
    logic                     lu_valid;
    logic                     lu_ready;
    logic [4:0]               lu_sel;
    logic [31:0]              lu_dat;
    logic                     freeze;
    logic                     rf_WEN;
    logic [4:0]               rf_wsel;
    logic [31:0]              rf_wdat;
    logic [4:0]               rsel1;
    logic [4:0]               rsel2;
    logic                     pend1;
    logic                     pend2;
`ifdef WBQ_BYPASS_EN
    logic [31:0]              fwd1;
    logic [31:0]              fwd2;
`endif
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;

    modport master (
        output wb_valid, wb_sel, wb_dat, lu_valid, lu_sel, lu_dat, freeze, rsel1, rsel2,
        input  wb_ready, lu_ready, rf_WEN, rf_wsel, rf_wdat, pend1, pend2, count, full, empty
`ifdef WBQ_BYPASS_EN
        , fwd1, fwd2
`endif
    );

    modport slave (
        input  wb_valid, wb_sel, wb_dat, lu_valid, lu_sel, lu_dat, freeze, rsel1, rsel2,
        output wb_ready, lu_ready, rf_WEN, rf_wsel, rf_wdat, pend1, pend2, count, full, empty
`ifdef WBQ_BYPASS_EN
        , fwd1, fwd2
`endif
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order register-file write queue fed by the writeback stage and the long-latency unit.
// Define WBQ_BYPASS_EN to add youngest-match data forwarding on fwd1/fwd2.
module regfile_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    regfile_writeback_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] FREE_ONE = (CW+1)'(1);
    localparam logic [CW:0] FREE_TWO = (CW+1)'(2);

    logic [4:0]     sel_mem [DEPTH];
    logic [31:0]    dat_mem [DEPTH];
    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;

    logic           deq;
    logic [CW:0]    free;
    logic           lu_need;
    logic           lu_rdy;
    logic           wb_rdy;
    logic           lu_enq;
    logic           wb_enq;
    logic [PW-1:0]  wb_slot;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    assign deq  = nRST && (count_reg != '0) && !bus.freeze;
    // The slot vacated by this cycle's retire is already reusable.
    assign free = (CW+1)'(DEPTH) - {1'b0, count_reg} + {{CW{1'b0}}, deq};

    assign lu_need = bus.lu_valid && (bus.lu_sel != 5'd0);
    assign lu_rdy  = nRST && ((bus.lu_sel == 5'd0) || (free >= FREE_ONE));
    assign wb_rdy  = nRST && ((bus.wb_sel == 5'd0) || (free >= FREE_TWO) ||
                              ((free == FREE_ONE) && !lu_need));
    assign lu_enq  = bus.lu_valid && lu_rdy && (bus.lu_sel != 5'd0);
    assign wb_enq  = bus.wb_valid && wb_rdy && (bus.wb_sel != 5'd0);
    assign wb_slot = lu_enq ? tail_reg + PW'(1) : tail_reg;

    assign count_next = count_reg + CW'(lu_enq) + CW'(wb_enq) - CW'(deq);

    always_ff @(posedge CLK) begin
        if (lu_enq) begin
            sel_mem[tail_reg] <= bus.lu_sel;
            dat_mem[tail_reg] <= bus.lu_dat;
        end
        if (wb_enq) begin
            sel_mem[wb_slot] <= bus.wb_sel;
            dat_mem[wb_slot] <= bus.wb_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PW'(deq);
            tail_reg  <= tail_reg + PW'(lu_enq) + PW'(wb_enq);
            count_reg <= count_next;
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] age;
            assign age             = PW'(gi) - head_reg;
            assign entry_valid[gi] = ({1'b0, age} < count_reg);
            assign match1[gi]      = entry_valid[gi] && (sel_mem[gi] == bus.rsel1);
            assign match2[gi]      = entry_valid[gi] && (sel_mem[gi] == bus.rsel2);
        end
    endgenerate

    assign bus.pend1 = nRST && (bus.rsel1 != 5'd0) && (|match1);
    assign bus.pend2 = nRST && (bus.rsel2 != 5'd0) && (|match2);

`ifdef WBQ_BYPASS_EN
    logic [31:0]   fwd1_next;
    logic [31:0]   fwd2_next;
    logic [PW-1:0] scan_idx;

    // Walk oldest to youngest so the last hit is the youngest value.
    always_comb begin
        fwd1_next = '0;
        fwd2_next = '0;
        scan_idx  = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PW'(k);
            if (match1[scan_idx]) fwd1_next = dat_mem[scan_idx];
            if (match2[scan_idx]) fwd2_next = dat_mem[scan_idx];
        end
    end

    assign bus.fwd1 = bus.pend1 ? fwd1_next : '0;
    assign bus.fwd2 = bus.pend2 ? fwd2_next : '0;
`endif

    assign bus.wb_ready = wb_rdy;
    assign bus.lu_ready = lu_rdy;
    assign bus.rf_WEN   = deq;
    assign bus.rf_wsel  = deq ? sel_mem[head_reg] : '0;
    assign bus.rf_wdat  = deq ? dat_mem[head_reg] : '0;
    assign bus.count    = nRST ? count_reg : '0;
    assign bus.full     = nRST && (count_reg == CW'(DEPTH));
    assign bus.empty    = nRST && (count_reg == '0);
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed plus randomized bench; a queue-based reference model predicts every output each cycle.
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] dat;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wb_valid = 1'b0; bus.wb_sel = '0; bus.wb_dat = '0;
        bus.lu_valid = 1'b0; bus.lu_sel = '0; bus.lu_dat = '0;
        bus.freeze   = 1'b0; bus.rsel1  = '0; bus.rsel2  = '0;
    endtask

    // Compare all outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic        wen, lr, wr, p1, p2, lu_acc, wb_acc;
        logic [31:0] f1, f2;
        int          free;
        ent_t        h;
        @(negedge clk);
        wen  = nrst && (q.size() != 0) && !bus.freeze;
        free = DEPTH - q.size() + (wen ? 1 : 0);
        lr   = nrst && (bus.lu_sel == 0 || free >= 1);
        wr   = nrst && (bus.wb_sel == 0 || free >= 2 ||
                        (free == 1 && !(bus.lu_valid && bus.lu_sel != 0)));
        h = '0;
        if (wen) h = q[0];
        p1 = 1'b0; f1 = '0; p2 = 1'b0; f2 = '0;
        foreach (q[i]) begin
            if (q[i].sel == bus.rsel1) begin p1 = 1'b1; f1 = q[i].dat; end
            if (q[i].sel == bus.rsel2) begin p2 = 1'b1; f2 = q[i].dat; end
        end
        if (!nrst || bus.rsel1 == 0) begin p1 = 1'b0; f1 = '0; end
        if (!nrst || bus.rsel2 == 0) begin p2 = 1'b0; f2 = '0; end

        chk("rf_WEN",   32'(bus.rf_WEN),   32'(wen));
        chk("rf_wsel",  32'(bus.rf_wsel),  32'(h.sel));
        chk("rf_wdat",  bus.rf_wdat,       h.dat);
        chk("lu_ready", 32'(bus.lu_ready), 32'(lr));
        chk("wb_ready", 32'(bus.wb_ready), 32'(wr));
        chk("count",    32'(bus.count),    nrst ? 32'(q.size()) : 32'd0);
        chk("full",     32'(bus.full),     32'(nrst && q.size() == DEPTH));
        chk("empty",    32'(bus.empty),    32'(nrst && q.size() == 0));
        chk("pend1",    32'(bus.pend1),    32'(p1));
        chk("pend2",    32'(bus.pend2),    32'(p2));
`ifdef WBQ_BYPASS_EN
        chk("fwd1",     bus.fwd1,          f1);
        chk("fwd2",     bus.fwd2,          f2);
`endif
        lu_acc = bus.lu_valid && lr && (bus.lu_sel != 0);
        wb_acc = bus.wb_valid && wr && (bus.wb_sel != 0);
        @(posedge clk);
        if (!nrst) begin
            q.delete();
        end else begin
            if (wen) void'(q.pop_front());
            if (lu_acc) q.push_back({bus.lu_sel, bus.lu_dat});
            if (wb_acc) q.push_back({bus.wb_sel, bus.wb_dat});
        end
        cyc++;
        #1;
    endtask

    initial begin
        idle();
        // Reset then idle
        nrst = 1'b0;
        cycle(); cycle();
        nrst = 1'b1;
        cycle();

        // Dual accept when empty: lu is older and retires first
        bus.lu_valid = 1'b1; bus.lu_sel = 5'd5; bus.lu_dat = 32'hAAAA0005;
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd6; bus.wb_dat = 32'h00000006;
        cycle();
        idle();
        cycle(); cycle(); cycle();

        // r0 writes are acknowledged but dropped
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd0; bus.wb_dat = 32'hDEADBEEF;
        cycle();
        idle();
        cycle(); cycle();

        // Fill under freeze, then release with an lu offer in the first free cycle
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.lu_valid = 1'b1; bus.lu_sel = 5'(10 + 2*i); bus.lu_dat = 32'h100 + 32'(i);
            bus.wb_valid = 1'b1; bus.wb_sel = 5'(11 + 2*i); bus.wb_dat = 32'h200 + 32'(i);
            cycle();
        end
        bus.freeze = 1'b0;
        bus.wb_valid = 1'b0;
        bus.lu_valid = 1'b1; bus.lu_sel = 5'd20; bus.lu_dat = 32'h300;
        cycle();
        idle();
        repeat (6) cycle();

        // Pending and forward with two writes to r7
        bus.freeze = 1'b1;
        bus.lu_valid = 1'b1; bus.lu_sel = 5'd7; bus.lu_dat = 32'h11;
        cycle();
        bus.lu_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd7; bus.wb_dat = 32'h22;
        cycle();
        bus.wb_valid = 1'b0;
        bus.rsel1 = 5'd7; bus.rsel2 = 5'd0;
        cycle();
        bus.freeze = 1'b0;
        cycle(); cycle(); cycle();
        idle();

        // Reset with three entries queued
        bus.freeze = 1'b1;
        bus.lu_valid = 1'b1; bus.lu_sel = 5'd3; bus.lu_dat = 32'h33;
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd4; bus.wb_dat = 32'h44;
        cycle();
        bus.wb_valid = 1'b0;
        bus.lu_sel = 5'd9; bus.lu_dat = 32'h99;
        cycle();
        idle();
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        cycle(); cycle();

        // Randomized traffic with occasional freeze and reset
        for (int n = 0; n < 400; n++) begin
            bus.lu_valid = 1'($urandom_range(0, 1));
            bus.lu_sel   = 5'($urandom_range(0, 7));
            bus.lu_dat   = $urandom;
            bus.wb_valid = 1'($urandom_range(0, 1));
            bus.wb_sel   = 5'($urandom_range(0, 7));
            bus.wb_dat   = $urandom;
            bus.freeze   = ($urandom_range(0, 3) == 0);
            bus.rsel1    = 5'($urandom_range(0, 7));
            bus.rsel2    = 5'($urandom_range(0, 7));
            nrst         = ($urandom_range(0, 63) != 0);
            cycle();
        end
        nrst = 1'b1;
        idle();
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side initiator for the register file. The block collects destination-register results from two producers: the pipeline writeback stage and the long-latency unit (mult/div). It buffers them in a small in-order queue and drives the register file write port (WEN/wsel/wdat) with one write per cycle. It also reports, for the two decode read selects, whether a younger value is still queued, and optionally forwards that value.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; synchronous, active-low.
- wb_valid  in  1  writeback stage offers a result.
- wb_ready  out  1  writeback result accepted this cycle.
- wb_sel  in  5  destination register.
- wb_dat  in  32  result (word_t).
- lu_valid  in  1  long-latency unit offers a result.
- lu_ready  out  1  long-latency result accepted this cycle.
- lu_sel  in  5  destination register.
- lu_dat  in  32  result.
- freeze  in  1  inhibits dequeue (halt/debug).
- rf_WEN  out  1  register file write enable.
- rf_wsel  out  5  register file write select.
- rf_wdat  out  32  register file write data.
- rsel1, rsel2  in  5  decode read selects.
- pend1, pend2  out  1  a queued write targets rselN.
- fwd1, fwd2  out  32  forwarded data; present only with the bypass macro (see Configuration).
- count  out  $clog2(DEPTH)+1  occupancy.
- full, empty  out  1  occupancy flags.

## Operation
- Circular buffer with head/tail pointers and a count. Each entry holds sel (5 bits) and dat (32 bits).
- **Dequeue:**
  - When !empty && !freeze: rf_WEN=1, rf_wsel/rf_wdat = head entry. Head advances at the edge.
  - Otherwise rf_WEN=0, and rf_wsel/rf_wdat are 0.
  - The register file always accepts the write.
- **Enqueue:** the number of free slots is computed from registered count plus the dequeue occurring this cycle, i.e. free = DEPTH - count + (rf_WEN ? 1 : 0).
  - lu_ready = (free >= 1).
  - wb_ready = (free >= 2) || (free == 1 && !lu_valid).
  - When both producers are accepted in one cycle, the lu entry is written first (older) and the wb entry second.
- **r0 filter:** an offer with sel==0 completes its handshake normally but is not enqueued and consumes no slot.
  - For the ready computation, an r0 offer counts as needing no slot.
- **Ordering:** writes retire strictly in acceptance order. Two queued writes to the same register both retire, and the younger one wins.
- **Pending lookup (combinational):**
  - pendN = 1 when rselN != 0 and any valid entry has sel == rselN.
  - The entry being dequeued this cycle still counts as pending.
- **Reset:**
  - The edge with nRST=0 clears head, tail and count, and discards all entries.
  - While nRST=0, all outputs are 0, including wb_ready and lu_ready.
  - Reset mid-operation drops queued writes; they never reach the register file.

## Timing
- A result accepted at edge N drives rf_WEN in cycle N (after that edge). The register file captures it at edge N+1, provided the queue was empty and freeze=0.
- Throughput: one retire per cycle; up to two accepts per cycle.
- Full with a dequeue in the same cycle: one slot is available, so lu_ready=1.
- Full with freeze=1: both readies are 0.
- Empty with both producers offering: both are accepted, and lu retires one cycle before wb.
- pend/fwd reflect state after the last edge. They do not see same-cycle offers from wb/lu.

## Configuration
- **WBQ_BYPASS_EN defined:**
  - fwdN = dat of the youngest valid entry matching rselN when pendN=1, else 0.
  - Decode uses fwdN directly and does not stall.
- **WBQ_BYPASS_EN undefined:**
  - fwd1/fwd2 ports are absent.
  - Decode must stall while pendN=1.
  - Matching logic is reduced to an OR of comparators.

## Test plan
- **Reset then idle:** nRST=0 for 2 cycles, then 1. Outputs are 0 during reset; afterwards count=0, empty=1, wb_ready=lu_ready=1, rf_WEN=0.
- **Dual accept when empty:** lu (r5, 0xAAAA0005) and wb (r6, 0x00000006) offered together. Both readies=1. Next cycle rf_WEN=1 with r5/0xAAAA0005, then r6/0x00000006, then rf_WEN=0.
- **r0 drop:** wb (r0, 0xDEADBEEF) offered. wb_ready=1, count stays 0, rf_WEN never asserts.
- **Fill under freeze:** freeze=1 while entries are offered until full=1 (count=4). Further offers see both readies=0. Release freeze: four consecutive writes retire in acceptance order, and lu_ready=1 in the first release cycle.
- **Pending/forward:** queue holds r7=0x11 (older) and r7=0x22 (younger), with freeze=1 and rsel1=7, rsel2=0. Expect pend1=1, pend2=0; with WBQ_BYPASS_EN, fwd1=0x22. After both retire, pend1=0.
- **Reset mid-operation:** nRST=0 with 3 entries queued. No further rf_WEN; after reset, count=0.
